rtc_calendar: RTL and testbench
===============================

Name: rtc_calendar

Overview:
Real-time clock/calendar that produces the hour, min, sec, year, month and day values consumed by the VGA clock-face and date renderer. It divides the board clock to a 1 Hz tick and carries through seconds, minutes, hours, days, months and years, with Gregorian leap-year handling. A field-write port lets switch/key logic set any field, with range checking and day clamping.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (prescaler terminal count + 1); must be >= 2
RST_YEAR, 2019, year loaded on reset
RST_MONTH, 12, month loaded on reset
RST_DAY, 26, day loaded on reset

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
clken  input  1  run enable; prescaler advances only while 1
set_en  input  1  single-cycle field-write strobe
set_field  input  3  0=sec 1=min 2=hour 3=day 4=month 5=year; 6,7 invalid
set_value  input  14  value to write (lower bits used for 6-bit fields)
sec  output  6  seconds 0..59
min  output  6  minutes 0..59
hour  output  6  hours 0..23
day  output  6  day 1..days_in_month
month  output  6  month 1..12
year  output  14  year 0..9999
tick  output  1  one-cycle pulse in the cycle the time advanced
set_err  output  1  one-cycle pulse, previous-cycle write rejected

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. All state is registered.
- Reset values: sec=min=hour=0; day=RST_DAY; month=RST_MONTH; year=RST_YEAR; prescaler=0; tick=0; set_err=0.
- Prescaler: counts 0..TICK_DIV-1 only when clken=1. It holds its value when clken=0.
  - Terminal count with clken=1 wraps it to 0 and raises internal advance.
- Advance: on the next clk edge, tick=1 for exactly one cycle and the counters update.
  - sec increments; 59 wraps to 0 and carries to min.
  - min 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0 and carries to day.
  - day equal to days_in_month wraps to 1 and carries to month.
  - month 12 wraps to 1 and carries to year.
  - year 9999 wraps to 0.
  - All carries resolve in the same edge; there are no intermediate visible states.
- days_in_month:
  - Months 1,3,5,7,8,10,12 have 31; months 4,6,9,11 have 30.
  - Month 2 has 29 if leap, else 28.
  - leap = (year%4==0 && year%100!=0) || year%400==0. Year 0 is leap.
- Write path: when set_en=1, the write is accepted on the same edge if set_value is in range for set_field.
  - Ranges: sec/min 0..59, hour 0..23, month 1..12, year 0..9999.
  - Day range is 1..days_in_month for the current month/year.
  - Writing sec also clears the prescaler to 0.
  - Writing month or year re-clamps day in the same edge: if day exceeds days_in_month of the new month/year, day becomes that maximum.
  - Out-of-range value or set_field 6/7: no state change, and set_err=1 for one cycle on the next edge.
- Simultaneous set_en and advance: the write takes priority. The advance in that cycle is dropped (tick stays 0) and the prescaler still wraps to 0.
- Writes are accepted regardless of clken.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), independent of clk. The first advance occurs TICK_DIV enabled cycles after reset deasserts.
- Latency: an accepted write is visible on the outputs the cycle after the set_en edge. Advance is visible together with tick.

Test Plan:
- Reset then TICK_DIV=4, clken=1 for 12 cycles -> tick pulses at cycles 4, 8, 12; sec=3; date reads 2019-12-26.
- Write 23:59:59 on 2019-12-31, one tick -> 00:00:00, 2020-01-01; exactly one tick pulse.
- Leap boundaries: 2020-02-28 23:59:59 + tick -> 02-29; 1900-02-28 23:59:59 + tick -> 03-01; 2000-02-28 23:59:59 + tick -> 02-29; 9999-12-31 23:59:59 + tick -> 0000-01-01.
- Invalid writes: min=60, hour=24, day=31 with month=4, field=7 -> state unchanged, set_err=1 one cycle each.
- Day clamp: day=31, month=1, then write month=2 in year 2019 -> day=28. Write year=2020 with month=2, day=29, then year=2021 -> day=28.
- Collision and reset: set_en (sec=10) on the same edge as terminal count -> sec=10, tick=0, prescaler=0. Assert reset asynchronously between edges mid-count -> outputs show 00:00:00 2019-12-26 before the next clk edge.

Source files
------------

// File: rtl/rtc_calendar.sv
// rtc_calendar: 1 Hz real-time clock/calendar with Gregorian leap years and a range-checked field-write port.
module rtc_calendar #(
   parameter int TICK_DIV  = 50000000,
   parameter int RST_YEAR  = 2019,
   parameter int RST_MONTH = 12,
   parameter int RST_DAY   = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clken,
   input  logic        set_en,
   input  logic [2:0]  set_field,
   input  logic [13:0] set_value,
   output logic [5:0]  sec,
   output logic [5:0]  min,
   output logic [5:0]  hour,
   output logic [5:0]  day,
   output logic [5:0]  month,
   output logic [13:0] year,
   output logic        tick,
   output logic        set_err
);
   localparam int PW = $clog2(TICK_DIV);

   function automatic logic [5:0] dim_f(input logic [5:0] m, input logic [13:0] y);
      logic leap;
      leap = (y % 14'd4 == 14'd0 && y % 14'd100 != 14'd0) || y % 14'd400 == 14'd0;
      return (m == 6'd2) ? (leap ? 6'd29 : 6'd28) :
             (m == 6'd4 || m == 6'd6 || m == 6'd9 || m == 6'd11) ? 6'd30 : 6'd31;
   endfunction

   logic [PW-1:0] pre;
   logic [5:0]    v6, dim_cur, dim_set;
   logic          hi, ok, wr_ok, adv, c_sec, c_min, c_hour, c_day, c_mon;

   always_comb begin
      v6      = set_value[5:0];
      hi      = |set_value[13:6];
      dim_cur = dim_f(month, year);
      // day clamp must use the month/year being written, not the current ones
      dim_set = dim_f(set_field == 3'd4 ? v6 : month, set_field == 3'd5 ? set_value : year);
      ok      = (set_field <= 3'd1) ? (!hi && v6 < 6'd60) :
                (set_field == 3'd2) ? (!hi && v6 < 6'd24) :
                (set_field == 3'd3) ? (!hi && v6 >= 6'd1 && v6 <= dim_cur) :
                (set_field == 3'd4) ? (!hi && v6 >= 6'd1 && v6 <= 6'd12) :
                (set_field == 3'd5) ? (set_value <= 14'd9999) : 1'b0;
      wr_ok   = set_en && ok;
      adv     = clken && pre == PW'(TICK_DIV - 1);
      c_sec   = sec == 6'd59;
      c_min   = c_sec && min == 6'd59;
      c_hour  = c_min && hour == 6'd23;
      c_day   = c_hour && day == dim_cur;
      c_mon   = c_day && month == 6'd12;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre     <= '0;
         sec     <= '0;
         min     <= '0;
         hour    <= '0;
         day     <= 6'(RST_DAY);
         month   <= 6'(RST_MONTH);
         year    <= 14'(RST_YEAR);
         tick    <= 1'b0;
         set_err <= 1'b0;
      end else begin
         tick    <= adv && !set_en;
         set_err <= set_en && !ok;
         pre     <= (adv || (wr_ok && set_field == 3'd0)) ? '0 : clken ? pre + 1'b1 : pre;
         if (wr_ok) begin
            case (set_field)
               3'd0: sec <= v6;
               3'd1: min <= v6;
               3'd2: hour <= v6;
               3'd3: day <= v6;
               3'd4: begin
                  month <= v6;
                  if (day > dim_set) day <= dim_set;
               end
               default: begin
                  year <= set_value;
                  if (day > dim_set) day <= dim_set;
               end
            endcase
         end else if (adv && !set_en) begin
            sec <= c_sec ? '0 : sec + 1'b1;
            if (c_sec) min <= c_min ? '0 : min + 1'b1;
            if (c_min) hour <= c_hour ? '0 : hour + 1'b1;
            if (c_hour) day <= c_day ? 6'd1 : day + 1'b1;
            if (c_day) month <= c_mon ? 6'd1 : month + 1'b1;
            if (c_mon) year <= (year == 14'd9999) ? '0 : year + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rtc_calendar.sv
// tb_rtc_calendar: directed table-driven bench for rtc_calendar with TICK_DIV=4.
module tb_rtc_calendar;
   logic        clk = 1'b0;
   logic        reset, clken, set_en;
   logic [2:0]  set_field;
   logic [13:0] set_value;
   logic [5:0]  sec, min, hour, day, month;
   logic [13:0] year;
   logic        tick, set_err;
   int          n_tests = 0, n_fail = 0;

   rtc_calendar #(.TICK_DIV(4), .RST_YEAR(2019), .RST_MONTH(12), .RST_DAY(26)) dut (
      .clk(clk), .reset(reset), .clken(clken), .set_en(set_en),
      .set_field(set_field), .set_value(set_value),
      .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
      .tick(tick), .set_err(set_err)
   );

   always #5 clk = ~clk;

   typedef struct { int y, mo, d, h, mi, s; longint e; } vec_t;
   typedef struct { logic [2:0] f; logic [13:0] v; } bad_t;
   vec_t v[9];
   bad_t b[9];

   localparam longint RST_DT = 64'd20191226000000;

   function automatic longint dt(input int y, input int mo, input int d, input int h, input int mi, input int s);
      return longint'(y) * 64'd10000000000 + longint'(mo) * 100000000 + longint'(d) * 1000000 + h * 10000 + mi * 100 + s;
   endfunction

   function automatic longint now_dt();
      return dt(int'(year), int'(month), int'(day), int'(hour), int'(min), int'(sec));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] f, input logic [13:0] val);
      set_field = f;
      set_value = val;
      set_en    = 1'b1;
      @(posedge clk);
      #1 set_en = 1'b0;
   endtask

   task automatic set_dt(input int y, input int mo, input int d, input int h, input int mi, input int s);
      wr(3'd5, 14'(y));
      wr(3'd4, 14'(mo));
      wr(3'd3, 14'(d));
      wr(3'd2, 14'(h));
      wr(3'd1, 14'(mi));
      wr(3'd0, 14'(s));
   endtask

   initial begin
      v[0] = '{2019, 12, 31, 23, 59, 59, 64'd20200101000000};
      v[1] = '{2020,  2, 28, 23, 59, 59, 64'd20200229000000};
      v[2] = '{1900,  2, 28, 23, 59, 59, 64'd19000301000000};
      v[3] = '{2000,  2, 28, 23, 59, 59, 64'd20000229000000};
      v[4] = '{9999, 12, 31, 23, 59, 59, 64'd00000101000000};
      v[5] = '{2021,  4, 30, 23, 59, 59, 64'd20210501000000};
      v[6] = '{2019,  6, 15, 10, 20, 30, 64'd20190615102031};
      v[7] = '{2019,  3, 10, 10, 59, 59, 64'd20190310110000};
      v[8] = '{2020,  2, 29, 23, 59, 59, 64'd20200301000000};
      b[0] = '{3'd1, 14'd60};
      b[1] = '{3'd2, 14'd24};
      b[2] = '{3'd3, 14'd31};
      b[3] = '{3'd7, 14'd5};
      b[4] = '{3'd0, 14'd60};
      b[5] = '{3'd4, 14'd13};
      b[6] = '{3'd4, 14'd0};
      b[7] = '{3'd5, 14'd10000};
      b[8] = '{3'd3, 14'd0};

      reset = 1'b1; clken = 1'b0; set_en = 1'b0; set_field = '0; set_value = '0;
      #2;
      chk("reset_dt", now_dt(), RST_DT);
      chk("reset_tick", tick, 1'b0);
      chk("reset_err", set_err, 1'b0);
      #10 reset = 1'b0;
      clken = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("run_tick%0d", i), tick, (i % 4 == 0));
      end
      chk("run_dt", now_dt(), RST_DT + 3);
      clken = 1'b0;

      for (int i = 0; i < 9; i++) begin
         set_dt(v[i].y, v[i].mo, v[i].d, v[i].h, v[i].mi, v[i].s);
         @(negedge clk);
         chk($sformatf("vec%0d_set", i), now_dt(), dt(v[i].y, v[i].mo, v[i].d, v[i].h, v[i].mi, v[i].s));
         chk($sformatf("vec%0d_err", i), set_err, 1'b0);
         clken = 1'b1;
         for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_tick%0d", i, k), tick, (k == 4));
         end
         chk($sformatf("vec%0d_dt", i), now_dt(), v[i].e);
         clken = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_tick_off", i), tick, 1'b0);
      end

      set_dt(2021, 4, 15, 10, 20, 30);
      for (int i = 0; i < 9; i++) begin
         wr(b[i].f, b[i].v);
         @(negedge clk);
         chk($sformatf("bad%0d_err", i), set_err, 1'b1);
         chk($sformatf("bad%0d_dt", i), now_dt(), 64'd20210415102030);
         @(negedge clk);
         chk($sformatf("bad%0d_err_clr", i), set_err, 1'b0);
      end

      wr(3'd5, 14'd2019);
      wr(3'd4, 14'd1);
      wr(3'd3, 14'd31);
      wr(3'd4, 14'd2);
      @(negedge clk);
      chk("clamp_feb2019", day, 6'd28);
      chk("clamp_month", month, 6'd2);
      wr(3'd5, 14'd2020);
      wr(3'd3, 14'd29);
      @(negedge clk);
      chk("leap_day29", day, 6'd29);
      wr(3'd5, 14'd2021);
      @(negedge clk);
      chk("clamp_2021", day, 6'd28);
      chk("clamp_err", set_err, 1'b0);

      wr(3'd0, 14'd5);
      clken = 1'b1;
      repeat (3) @(posedge clk);
      #1 wr(3'd0, 14'd10);
      @(negedge clk);
      chk("coll_sec", sec, 6'd10);
      chk("coll_tick", tick, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("coll_tick%0d", k), tick, (k == 4));
      end
      chk("coll_sec_after", sec, 6'd11);

      @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_dt", now_dt(), RST_DT);
      chk("async_tick", tick, 1'b0);
      #1 reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("post_rst_tick%0d", k), tick, (k == 4));
      end
      chk("post_rst_dt", now_dt(), RST_DT + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
